// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the arbiters in this directory.
package arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  localparam int WBUS = 1024;
  function automatic logic [31:0] weight_field(input logic [WBUS-1:0] w, input int i, input int ww);
    return 32'(w >> (i * ww));
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority picker returning the first requester at or after ptr.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] rot;
  int sel, sum;
  always_comb begin
    rot = N'({req, req} >> ptr);
    sel = 0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) sel = k;
    sum = int'(ptr) + sel;
    any = |req;
    idx = any ? IW'(sum >= N ? sum - N : sum) : '0;
    onehot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: weighted round-robin arbiter granting bursts of up to weight[i] beats.
module wrr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int WW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            beat_valid,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_idx,
  output logic            busy
);
  arb_state_e state_q, state_d;
  logic [N-1:0] grant_q, grant_d, pick_oh;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, pick_idx;
  logic [WW-1:0] credit_q, credit_d, w_sel;
  logic pick_any, release_c;
  rr_pick #(.N(N)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .onehot(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign w_sel = WW'(weight_field(WBUS'(weight), int'(pick_idx), WW));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    credit_d = credit_q;
    release_c = 1'b0;
    if (state_q == IDLE) begin
      if (pick_any) begin
        state_d = GRANT;
        grant_d = pick_oh;
        idx_d = pick_idx;
        credit_d = (w_sel == '0) ? WW'(1) : w_sel;
      end
    end else begin
      // a final beat coinciding with a request drop still yields a single release
      release_c = (beat_valid && credit_q == WW'(1)) || !req[idx_q];
      if (release_c) begin
        state_d = IDLE;
        grant_d = '0;
        idx_d = '0;
        credit_d = '0;
        ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
      end else if (beat_valid) begin
        credit_d = credit_q - WW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      credit_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      credit_q <= credit_d;
    end
  end
  assign grant = grant_q;
  assign grant_idx = idx_q;
  assign busy = (state_q == GRANT);
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_busy: assert property (@(posedge clk) disable iff (!rst_n) busy == |grant_q);
  a_idx: assert property (@(posedge clk) disable iff (!rst_n) grant_q == (busy ? N'(1) << idx_q : '0));
  a_ptr: assert property (@(posedge clk) disable iff (!rst_n) int'(ptr_q) < N);
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb_wrr_burst_arbiter: directed table and sequence checks for the WRR burst arbiter.
module tb_wrr_burst_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, grant;
  logic [15:0] weight;
  logic beat_valid, busy;
  logic [1:0] grant_idx;
  logic [2:0] req3, grant3;
  logic [11:0] weight3;
  logic beat_valid3, busy3;
  logic [1:0] grant_idx3;
  int ncmp = 0;
  int nfail = 0;
  typedef struct {
    logic [3:0] req;
    logic [15:0] w;
    logic bv;
    int g;
    int idx;
  } vec_t;
  vec_t tbl[17];
  always #5 clk = ~clk;
  wrr_burst_arbiter #(.N(4), .WW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .weight(weight), .beat_valid(beat_valid),
    .grant(grant), .grant_idx(grant_idx), .busy(busy)
  );
  wrr_burst_arbiter #(.N(3), .WW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .weight(weight3), .beat_valid(beat_valid3),
    .grant(grant3), .grant_idx(grant_idx3), .busy(busy3)
  );
  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_out(input string name, input int g, input int i);
    chk({name, ".grant"}, int'(grant), g);
    chk({name, ".idx"}, int'(grant_idx), i);
    chk({name, ".busy"}, int'(busy), int'(g != 0));
  endtask
  task automatic chk3(input string name, input int g, input int i);
    chk({name, ".grant"}, int'(grant3), g);
    chk({name, ".idx"}, int'(grant_idx3), i);
    chk({name, ".busy"}, int'(busy3), int'(g != 0));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    beat_valid = 1'b0;
    req3 = '0;
    beat_valid3 = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    req = '0;
    weight = '0;
    beat_valid = 1'b0;
    req3 = '0;
    weight3 = '0;
    beat_valid3 = 1'b0;
    #1;
    chk_out("reset", 0, 0);
    chk3("reset3", 0, 0);
    repeat (2) step();
    rst_n = 1'b1;
    // stray beats, then full rotation with weights {1,2,3,4}
    tbl[0] = '{4'b0000, 16'h4321, 1'b1, 0, 0};
    tbl[1] = '{4'b0000, 16'h4321, 1'b1, 0, 0};
    tbl[2] = '{4'b1111, 16'h4321, 1'b1, 1, 0};
    tbl[3] = '{4'b1111, 16'h4321, 1'b1, 0, 0};
    tbl[4] = '{4'b1111, 16'h4321, 1'b1, 2, 1};
    tbl[5] = '{4'b1111, 16'h4321, 1'b1, 2, 1};
    tbl[6] = '{4'b1111, 16'h4321, 1'b1, 0, 0};
    tbl[7] = '{4'b1111, 16'h4321, 1'b1, 4, 2};
    tbl[8] = '{4'b1111, 16'h4321, 1'b1, 4, 2};
    tbl[9] = '{4'b1111, 16'h4321, 1'b1, 4, 2};
    tbl[10] = '{4'b1111, 16'h4321, 1'b1, 0, 0};
    tbl[11] = '{4'b1111, 16'h4321, 1'b1, 8, 3};
    tbl[12] = '{4'b1111, 16'h4321, 1'b1, 8, 3};
    tbl[13] = '{4'b1111, 16'h4321, 1'b1, 8, 3};
    tbl[14] = '{4'b1111, 16'h4321, 1'b1, 8, 3};
    tbl[15] = '{4'b1111, 16'h4321, 1'b1, 0, 0};
    tbl[16] = '{4'b1111, 16'h4321, 1'b1, 1, 0};
    for (int i = 0; i < 17; i++) begin
      req = tbl[i].req;
      weight = tbl[i].w;
      beat_valid = tbl[i].bv;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].idx);
    end
    // asynchronous reset mid-burst
    do_reset();
    weight = 16'h4321;
    req = 4'b0100;
    step();
    chk_out("mb_load", 4, 2);
    beat_valid = 1'b1;
    step();
    chk_out("mb_beat", 4, 2);
    req = 4'b1111;
    beat_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_out("mb_async", 0, 0);
    #1 rst_n = 1'b1;
    step();
    chk_out("mb_first", 1, 0);
    // early drop of req[2] after one beat
    do_reset();
    weight = 16'h4321;
    req = 4'b0100;
    step();
    chk_out("ed_load", 4, 2);
    beat_valid = 1'b1;
    step();
    chk_out("ed_beat", 4, 2);
    req = 4'b1011;
    beat_valid = 1'b0;
    step();
    chk_out("ed_rel", 0, 0);
    step();
    chk_out("ed_next", 8, 3);
    // zero weight with a stall
    do_reset();
    weight = 16'h4301;
    req = 4'b0010;
    step();
    chk_out("zw_load", 2, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("zw_stall%0d", i), 2, 1);
    end
    beat_valid = 1'b1;
    step();
    chk_out("zw_rel", 0, 0);
    // final beat coinciding with request drop
    do_reset();
    weight = 16'h4321;
    req = 4'b0001;
    step();
    chk_out("sd_load", 1, 0);
    req = 4'b0000;
    beat_valid = 1'b1;
    step();
    chk_out("sd_rel", 0, 0);
    beat_valid = 1'b0;
    step();
    chk_out("sd_idle", 0, 0);
    // weight change mid-burst is ignored
    do_reset();
    weight = 16'h4321;
    req = 4'b0010;
    step();
    chk_out("wc_load", 2, 1);
    weight = 16'h43F1;
    beat_valid = 1'b1;
    step();
    chk_out("wc_beat", 2, 1);
    step();
    chk_out("wc_rel", 0, 0);
    // N=3 wrap and skip
    do_reset();
    weight3 = 12'h111;
    req3 = 3'b010;
    step();
    chk3("n3_load1", 2, 1);
    req3 = 3'b001;
    step();
    chk3("n3_rel1", 0, 0);
    req3 = 3'b011;
    step();
    chk3("n3_wrap", 1, 0);
    beat_valid3 = 1'b1;
    step();
    chk3("n3_rel2", 0, 0);
    beat_valid3 = 1'b0;
    step();
    chk3("n3_next", 2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream resource among N requesters.
- Grants are burst-oriented. The winner holds a registered one-hot grant for up to weight[i] accepted beats, or until it drops its request.
- The rotating pointer then advances past the winner.
- Sits between requester queues and a shared bus or engine. The engine reports accepted beats on beat_valid.

Parameters:
- N, 4, number of requesters; any N >= 2, power of two not required.
- WW, 4, width of each per-requester weight field.
- IW, $clog2(N), width of the index and pointer (derived, not overridden).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  N  request lines; req[i] held high while requester i has beats pending
- weight  input  N*WW  flattened weights; field i = weight[i*WW +: WW] = max beats per grant for requester i
- beat_valid  input  1  resource accepted one beat from the current grantee this cycle
- grant  output  N  registered one-hot grant, all-zero when idle
- grant_idx  output  IW  index of the current grantee; 0 when idle
- busy  output  1  high while in state GRANT (equals |grant)

Behaviour:
- Reset values: state=IDLE, grant=0, grant_idx=0, busy=0, ptr=0, credit=0. All state is cleared asynchronously on rst_n low, including mid-burst.
- State IDLE:
  - At a rising edge with |req==1, pick the first requesting index scanning ptr, ptr+1, ..., wrapping N-1 -> 0.
  - Load grant=onehot(idx), grant_idx=idx, credit=weight[idx] (weight 0 loads as 1), state=GRANT.
  - With no request, stay in IDLE.
- Latency: req first high in cycle t gives grant high in cycle t+1.
- State GRANT, per edge:
  - beat_valid decrements credit by 1.
  - Release when either (a) beat_valid and credit==1, or (b) req[grant_idx]==0.
  - On release: grant=0, grant_idx=0, state=IDLE, ptr=(grant_idx==N-1)?0:grant_idx+1.
  - Without release: hold grant and grant_idx unchanged.
- Simultaneous final beat and req drop: the beat is counted; one release only.
- Always one idle cycle (grant=0) between consecutive grants. Re-arbitration occurs on the edge following release.
- Weights are sampled only at grant load. A weight change mid-burst has no effect on the current burst.
- Requests from other requesters during GRANT do not preempt.
- beat_valid in IDLE is ignored. No state change.
- Credit register width is WW. No underflow: credit never decrements below 1 without releasing.
- Pointer wrap uses an explicit compare against N-1, not a modulo on a power-of-two width, so non-power-of-two N is correct.
- Assertions (disabled while rst_n low):
  - $onehot0(grant).
  - busy == |grant.
  - grant_idx matches grant.
  - ptr < N.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_e.
  - Function to extract weight field i from the flattened vector.
- Sub-module rr_pick: combinational priority picker.
  - Inputs: req[N], ptr[IW].
  - Outputs: onehot[N], idx[IW], any.
  - Rotation via double-width vector with an explicit wrap for non-power-of-two N.
  - Reusable by the other arbiters in the directory.
- wrr_burst_arbiter holds the FSM, credit counter, pointer and output registers.

Test Plan:
- Reset: assert rst_n low mid-burst (req=4'b1111, grant=4'b0100, credit 2) -> grant=0, busy=0, grant_idx=0 asynchronously. After release, the first grant is requester 0.
- Full rotation: N=4, weights {1,2,3,4} for indices 0..3, req=4'b1111 held, beat_valid=1 every cycle -> grant 0001 for 1 cycle, idle 1, 0010 for 2, idle 1, 0100 for 3, idle 1, 1000 for 4, idle, then 0001 again.
- Early drop: req[2] deasserted after 1 beat of a weight-3 grant -> release on that edge, ptr=3, next grant 1000 when req[3]=1.
- Zero weight and stall: weight[1]=0, beat_valid low for 5 cycles then one pulse -> grant 0010 held through the stall, released after exactly 1 beat.
- Wrap and skip: N=3 build, ptr=2, req=3'b011 -> grant 001. After release ptr=1, so next grant is 010.
- Stray beat: beat_valid=1 with req=0 in IDLE -> no grant and no state change. Assertions stay silent throughout all scenarios.
